wb_per_switch: RTL and testbench

WB_PER_SWITCH -- requirements
Module: wb_per_switch

---
 rtl/wb_per_switch.sv | 186 ++++++++++++++++++
 tb/tb_wb_per_switch.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_per_switch.sv
// rtl/wb_per_switch.sv - single-master Wishbone switch fanning out to NUM_SLAVES address-decoded slaves
// Registered request path with per-transfer ack timeout and saturating error counter.
module wb_per_switch #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE =
    {32'h8000_0300, 32'h8000_0200, 32'h8000_0100, 32'h8000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {4{32'hFFFF_FF00}},
  parameter int TIMEOUT    = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         master_stb_i,
  input  logic                         master_we_i,
  input  logic [ADDR_W-1:0]            master_adr_i,
  input  logic [DATA_W-1:0]            master_dat_i,
  input  logic [DATA_W/8-1:0]          master_sel_i,
  output logic [DATA_W-1:0]            master_dat_o,
  output logic                         master_ack_o,
  output logic                         master_err_o,
  output logic [NUM_SLAVES-1:0]        slave_cyc_o,
  output logic [NUM_SLAVES-1:0]        slave_stb_o,
  output logic                         slave_we_o,
  output logic [ADDR_W-1:0]            slave_adr_o,
  output logic [DATA_W-1:0]            slave_dat_o,
  output logic [DATA_W/8-1:0]          slave_sel_o,
  input  logic [NUM_SLAVES*DATA_W-1:0] slave_dat_i,
  input  logic [NUM_SLAVES-1:0]        slave_ack_i,
  output logic [7:0]                   err_count_o
);

  localparam int          IDX_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [IDX_W-1:0]        idx_r;
  logic [NUM_SLAVES-1:0]   stb_r;
  logic [15:0]             tmo_cnt;

  logic                    hit_any;
  logic [IDX_W-1:0]        hit_idx;
  logic [NUM_SLAVES-1:0]   hit_oh;
  logic                    sel_ack;
  logic [DATA_W-1:0]       sel_dat;
  logic                    timeout_hit;

  logic                    accept;
  logic                    finish_ack;
  logic                    finish_tmo;
  logic                    ack_nxt;
  logic                    err_nxt;

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    hit_oh  = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((master_adr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W]) ==
          (SLAVE_BASE[i*ADDR_W +: ADDR_W] & SLAVE_MASK[i*ADDR_W +: ADDR_W])) begin
        hit_any   = 1'b1;
        hit_idx   = IDX_W'(i);
        hit_oh    = '0;
        hit_oh[i] = 1'b1;
      end
    end
  end

  // Only the latched slave's ack and data are ever looked at.
  always_comb begin
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (idx_r == IDX_W'(i)) begin
        sel_ack = slave_ack_i[i];
        sel_dat = slave_dat_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign timeout_hit = ((tmo_cnt + 16'd1) == TMO_LIMIT);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (master_stb_i) begin
          state_nxt = hit_any ? S_ACTIVE : S_DONE;
        end
      end
      S_ACTIVE: begin
        if (sel_ack || timeout_hit) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Ack is tested before the timeout so a last-cycle ack still completes cleanly.
  always_comb begin
    accept     = 1'b0;
    finish_ack = 1'b0;
    finish_tmo = 1'b0;
    ack_nxt    = 1'b0;
    err_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        if (master_stb_i) begin
          accept  = hit_any;
          err_nxt = !hit_any;
        end
      end
      S_ACTIVE: begin
        if (sel_ack) begin
          finish_ack = 1'b1;
          ack_nxt    = 1'b1;
        end else if (timeout_hit) begin
          finish_tmo = 1'b1;
          err_nxt    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idx_r        <= '0;
      stb_r        <= '0;
      tmo_cnt      <= '0;
      slave_we_o   <= 1'b0;
      slave_adr_o  <= '0;
      slave_dat_o  <= '0;
      slave_sel_o  <= '0;
      master_dat_o <= '0;
      master_ack_o <= 1'b0;
      master_err_o <= 1'b0;
      err_count_o  <= '0;
    end else begin
      master_ack_o <= ack_nxt;
      master_err_o <= err_nxt;
      if (accept) begin
        idx_r       <= hit_idx;
        stb_r       <= hit_oh;
        tmo_cnt     <= '0;
        slave_we_o  <= master_we_i;
        slave_adr_o <= master_adr_i;
        slave_dat_o <= master_dat_i;
        slave_sel_o <= master_sel_i;
      end else if (state == S_ACTIVE) begin
        if (finish_ack || finish_tmo) begin
          stb_r <= '0;
        end else begin
          tmo_cnt <= tmo_cnt + 16'd1;
        end
      end
      if (finish_ack && !slave_we_o) begin
        master_dat_o <= sel_dat;
      end
      if (err_nxt && (err_count_o != 8'hFF)) begin
        err_count_o <= err_count_o + 8'd1;
      end
    end
  end

  assign slave_cyc_o = stb_r;
  assign slave_stb_o = stb_r;

endmodule

// File: tb/tb_wb_per_switch.sv
// tb/tb_wb_per_switch.sv - directed self-checking bench for wb_per_switch
module tb_wb_per_switch;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         master_stb_i;
  logic         master_we_i;
  logic [31:0]  master_adr_i;
  logic [31:0]  master_dat_i;
  logic [3:0]   master_sel_i;
  logic [31:0]  master_dat_o;
  logic         master_ack_o;
  logic         master_err_o;
  logic [3:0]   slave_cyc_o;
  logic [3:0]   slave_stb_o;
  logic         slave_we_o;
  logic [31:0]  slave_adr_o;
  logic [31:0]  slave_dat_o;
  logic [3:0]   slave_sel_o;
  logic [127:0] slave_dat_i;
  logic [3:0]   slave_ack_i;
  logic [7:0]   err_count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  wb_per_switch #(.TIMEOUT(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .master_stb_i (master_stb_i),
    .master_we_i  (master_we_i),
    .master_adr_i (master_adr_i),
    .master_dat_i (master_dat_i),
    .master_sel_i (master_sel_i),
    .master_dat_o (master_dat_o),
    .master_ack_o (master_ack_o),
    .master_err_o (master_err_o),
    .slave_cyc_o  (slave_cyc_o),
    .slave_stb_o  (slave_stb_o),
    .slave_we_o   (slave_we_o),
    .slave_adr_o  (slave_adr_o),
    .slave_dat_o  (slave_dat_o),
    .slave_sel_o  (slave_sel_o),
    .slave_dat_i  (slave_dat_i),
    .slave_ack_i  (slave_ack_i),
    .err_count_o  (err_count_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic request(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
    master_stb_i = 1'b1;
    master_we_i  = we;
    master_adr_i = adr;
    master_dat_i = dat;
    master_sel_i = sel;
  endtask

  initial begin
    rst_i        = 1'b0;
    master_stb_i = 1'b0;
    master_we_i  = 1'b0;
    master_adr_i = '0;
    master_dat_i = '0;
    master_sel_i = '0;
    slave_dat_i  = '0;
    slave_ack_i  = '0;
    tick();
    tick();
    check("rst_stb", slave_stb_o, 4'h0);
    check("rst_cyc", slave_cyc_o, 4'h0);
    check("rst_ack", master_ack_o, 1'b0);
    check("rst_err", master_err_o, 1'b0);
    check("rst_dat", master_dat_o, 32'h0);
    check("rst_sadr", slave_adr_o, 32'h0);
    check("rst_errcnt", err_count_o, 8'h0);

    // Read of slave 1 issued on the very first edge out of reset.
    rst_i = 1'b1;
    request(1'b0, 32'h8000_0104, 32'h0, 4'hF);
    tick();
    check("rd_stb", slave_stb_o, 4'b0010);
    check("rd_cyc", slave_cyc_o, 4'b0010);
    check("rd_sadr", slave_adr_o, 32'h8000_0104);
    check("rd_swe", slave_we_o, 1'b0);
    tick();
    check("rd_stb_hold", slave_stb_o, 4'b0010);
    check("rd_noack", master_ack_o, 1'b0);
    slave_ack_i = 4'b0010;
    slave_dat_i[32 +: 32] = 32'hDEAD_BEEF;
    tick();
    slave_ack_i  = '0;
    master_stb_i = 1'b0;
    check("rd_ack", master_ack_o, 1'b1);
    check("rd_err", master_err_o, 1'b0);
    check("rd_dat", master_dat_o, 32'hDEAD_BEEF);
    check("rd_stb_drop", slave_stb_o, 4'h0);
    tick();
    check("rd_ack_pulse", master_ack_o, 1'b0);
    check("rd_dat_hold", master_dat_o, 32'hDEAD_BEEF);

    // Write to slave 0 with a spurious ack from slave 2 in its first cycle.
    slave_dat_i[0 +: 32] = 32'h1111_1111;
    slave_dat_i[64 +: 32] = 32'h2222_2222;
    request(1'b1, 32'h8000_0008, 32'h0000_00A5, 4'h1);
    tick();
    check("wr_stb", slave_stb_o, 4'b0001);
    check("wr_swe", slave_we_o, 1'b1);
    check("wr_sdat", slave_dat_o, 32'h0000_00A5);
    check("wr_ssel", slave_sel_o, 4'h1);
    slave_ack_i = 4'b0100;
    tick();
    check("spur_ack", master_ack_o, 1'b0);
    check("spur_err", master_err_o, 1'b0);
    check("spur_stb", slave_stb_o, 4'b0001);
    slave_ack_i = 4'b0001;
    tick();
    slave_ack_i  = '0;
    master_stb_i = 1'b0;
    check("wr_ack", master_ack_o, 1'b1);
    check("wr_dat_keep", master_dat_o, 32'hDEAD_BEEF);
    tick();
    check("wr_ack_pulse", master_ack_o, 1'b0);

    // Decode miss.
    request(1'b0, 32'h9000_0000, 32'h0, 4'hF);
    tick();
    master_stb_i = 1'b0;
    check("miss_stb", slave_stb_o, 4'h0);
    check("miss_err", master_err_o, 1'b1);
    check("miss_ack", master_ack_o, 1'b0);
    check("miss_cnt", err_count_o, 8'd1);
    tick();
    check("miss_err_pulse", master_err_o, 1'b0);

    // Timeout on slave 3, then a late ack that must be ignored.
    request(1'b0, 32'h8000_0300, 32'h0, 4'hF);
    for (int c = 0; c < 4; c++) begin
      tick();
      check($sformatf("tmo_hold%0d", c), slave_stb_o, 4'b1000);
      check($sformatf("tmo_noerr%0d", c), master_err_o, 1'b0);
    end
    tick();
    check("tmo_drop", slave_stb_o, 4'h0);
    check("tmo_err", master_err_o, 1'b1);
    check("tmo_ack", master_ack_o, 1'b0);
    check("tmo_cnt", err_count_o, 8'd2);
    master_stb_i = 1'b0;
    slave_ack_i  = 4'b1000;
    tick();
    check("late_ack", master_ack_o, 1'b0);
    check("late_err", master_err_o, 1'b0);
    tick();
    slave_ack_i = '0;
    check("late_ack2", master_ack_o, 1'b0);
    check("late_stb", slave_stb_o, 4'h0);

    // Ack in the cycle the counter hits the limit: ack wins.
    request(1'b0, 32'h8000_0200, 32'h0, 4'hF);
    tick();
    check("race_stb", slave_stb_o, 4'b0100);
    tick();
    tick();
    tick();
    slave_ack_i = 4'b0100;
    slave_dat_i[64 +: 32] = 32'hCAFE_F00D;
    tick();
    slave_ack_i  = '0;
    master_stb_i = 1'b0;
    check("race_ack", master_ack_o, 1'b1);
    check("race_err", master_err_o, 1'b0);
    check("race_dat", master_dat_o, 32'hCAFE_F00D);
    check("race_cnt", err_count_o, 8'd2);
    tick();

    // Reset in the middle of an active transfer.
    request(1'b0, 32'h8000_0100, 32'h0, 4'hF);
    tick();
    check("abort_stb_pre", slave_stb_o, 4'b0010);
    #2;
    rst_i = 1'b0;
    #1;
    check("abort_stb_async", slave_stb_o, 4'h0);
    check("abort_cnt", err_count_o, 8'd0);
    master_stb_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
    check("abort_ack", master_ack_o, 1'b0);
    check("abort_err", master_err_o, 1'b0);
    check("abort_stb", slave_stb_o, 4'h0);
    request(1'b0, 32'h8000_0100, 32'h0, 4'hF);
    tick();
    check("post_stb", slave_stb_o, 4'b0010);
    slave_ack_i = 4'b0010;
    slave_dat_i[32 +: 32] = 32'h1234_5678;
    tick();
    slave_ack_i  = '0;
    master_stb_i = 1'b0;
    check("post_ack", master_ack_o, 1'b1);
    check("post_dat", master_dat_o, 32'h1234_5678);
    tick();

    // Error counter saturation.
    for (int n = 0; n < 256; n++) begin
      request(1'b0, 32'h9000_0000, 32'h0, 4'hF);
      tick();
      master_stb_i = 1'b0;
      if (n == 254) check("sat_255", err_count_o, 8'd255);
      tick();
    end
    check("sat_hold", err_count_o, 8'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
